// File: rtl/avmm_master_rw8.sv
// Avalon-MM initiator for 8-bit waitrequest slaves: one command becomes N single
// transfers, each answered by one response pulse, with a per-beat stall timeout.
module avmm_master_rw8 #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 5,
  parameter int TIMEOUT = 63
) (
  input  logic              csi_MCLK_clk,
  input  logic              rsi_MRST_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic              cmd_incr,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [ADDR_W-1:0] avm_test_address,
  output logic [DATA_W-1:0] avm_test_writedata,
  input  logic [DATA_W-1:0] avm_test_readdata,
  output logic              avm_test_write,
  output logic              avm_test_read,
  input  logic              avm_test_waitrequest
);

  typedef enum logic [1:0] {IDLE, ACCESS, GAP} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] base, base_n, addr_n;
  logic [DATA_W-1:0] seed, seed_n, wdata_n, rsp_data_n;
  logic [CNT_W-1:0]  count, count_n, k, k_n;
  logic              incr, incr_n, is_write, is_write_n;
  logic [7:0]        wait_cnt, wait_cnt_n;
  logic              rd_n, wr_n, rsp_valid_n, rsp_last_n, rsp_timeout_n;
  logic              ready_n, busy_n;

  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      state              <= IDLE;
      base               <= '0;
      seed               <= '0;
      count              <= '0;
      k                  <= '0;
      incr               <= 1'b0;
      is_write           <= 1'b0;
      wait_cnt           <= '0;
      cmd_ready          <= 1'b0;
      busy               <= 1'b0;
      rsp_valid          <= 1'b0;
      rsp_data           <= '0;
      rsp_last           <= 1'b0;
      rsp_timeout        <= 1'b0;
      avm_test_address   <= '0;
      avm_test_writedata <= '0;
      avm_test_read      <= 1'b0;
      avm_test_write     <= 1'b0;
    end else begin
      state              <= state_n;
      base               <= base_n;
      seed               <= seed_n;
      count              <= count_n;
      k                  <= k_n;
      incr               <= incr_n;
      is_write           <= is_write_n;
      wait_cnt           <= wait_cnt_n;
      cmd_ready          <= ready_n;
      busy               <= busy_n;
      rsp_valid          <= rsp_valid_n;
      rsp_data           <= rsp_data_n;
      rsp_last           <= rsp_last_n;
      rsp_timeout        <= rsp_timeout_n;
      avm_test_address   <= addr_n;
      avm_test_writedata <= wdata_n;
      avm_test_read      <= rd_n;
      avm_test_write     <= wr_n;
    end
  end

  // Every output is registered, so this block computes the value each output
  // takes in the cycle following the current edge.
  always_comb begin
    state_n       = state;
    base_n        = base;
    seed_n        = seed;
    count_n       = count;
    k_n           = k;
    incr_n        = incr;
    is_write_n    = is_write;
    wait_cnt_n    = wait_cnt;
    ready_n       = cmd_ready;
    busy_n        = busy;
    rsp_valid_n   = 1'b0;
    rsp_data_n    = '0;
    rsp_last_n    = 1'b0;
    rsp_timeout_n = 1'b0;
    addr_n        = avm_test_address;
    wdata_n       = avm_test_writedata;
    rd_n          = avm_test_read;
    wr_n          = avm_test_write;

    case (state)
      IDLE: begin
        ready_n = 1'b1;
        busy_n  = 1'b0;
        if (cmd_valid && cmd_ready) begin
          base_n     = cmd_address;
          seed_n     = cmd_wdata;
          count_n    = cmd_count;
          incr_n     = cmd_incr;
          is_write_n = cmd_write;
          k_n        = '0;
          wait_cnt_n = '0;
          addr_n     = cmd_address;
          wdata_n    = cmd_wdata;
          wr_n       = cmd_write;
          rd_n       = ~cmd_write;
          ready_n    = 1'b0;
          busy_n     = 1'b1;
          state_n    = ACCESS;
        end
      end

      ACCESS: begin
        if (!avm_test_waitrequest) begin
          rd_n        = 1'b0;
          wr_n        = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_data_n  = is_write ? '0 : avm_test_readdata;
          rsp_last_n  = (k == count);
          if (k == count) begin
            ready_n = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
          end else begin
            k_n     = k + CNT_W'(1);
            state_n = GAP;
          end
        end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
          // This stall cycle is the TIMEOUT-th one: abort and drop remaining beats.
          rd_n          = 1'b0;
          wr_n          = 1'b0;
          rsp_valid_n   = 1'b1;
          rsp_last_n    = 1'b1;
          rsp_timeout_n = 1'b1;
          ready_n       = 1'b1;
          busy_n        = 1'b0;
          state_n       = IDLE;
        end else begin
          wait_cnt_n = wait_cnt + 8'd1;
        end
      end

      GAP: begin
        wait_cnt_n = '0;
        addr_n     = incr ? base + ADDR_W'(k) : base;
        wdata_n    = seed + DATA_W'(k);
        wr_n       = is_write;
        rd_n       = ~is_write;
        state_n    = ACCESS;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_avmm_master_rw8.sv
// Directed bench for avmm_master_rw8: a behavioural wait-state slave plus
// scoreboards of expected bus beats and expected responses.
module tb_avmm_master_rw8;

  localparam int TO = 63;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_write, cmd_incr;
  logic [5:0] cmd_address;
  logic [7:0] cmd_wdata;
  logic [4:0] cmd_count;
  logic       rsp_valid, rsp_last, rsp_timeout, busy;
  logic [7:0] rsp_data;
  logic [5:0] avm_test_address;
  logic [7:0] avm_test_writedata, avm_test_readdata;
  logic       avm_test_write, avm_test_read, avm_test_waitrequest;

  avmm_master_rw8 #(.ADDR_W(6), .DATA_W(8), .CNT_W(5), .TIMEOUT(TO)) dut (
    .csi_MCLK_clk        (clk),
    .rsi_MRST_reset      (rst),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_write           (cmd_write),
    .cmd_address         (cmd_address),
    .cmd_wdata           (cmd_wdata),
    .cmd_count           (cmd_count),
    .cmd_incr            (cmd_incr),
    .rsp_valid           (rsp_valid),
    .rsp_data            (rsp_data),
    .rsp_last            (rsp_last),
    .rsp_timeout         (rsp_timeout),
    .busy                (busy),
    .avm_test_address    (avm_test_address),
    .avm_test_writedata  (avm_test_writedata),
    .avm_test_readdata   (avm_test_readdata),
    .avm_test_write      (avm_test_write),
    .avm_test_read       (avm_test_read),
    .avm_test_waitrequest(avm_test_waitrequest)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] data; logic last; logic tmo; int due; } rsp_t;
  typedef struct { logic [5:0] addr; logic [7:0] data; logic wr; } beat_t;

  rsp_t       rspq[$];
  beat_t      beatq[$];
  logic [7:0] rdq[$];
  int         wait_cycles = 0;
  bit         stuck = 1'b0;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_cmd(input logic wr, input logic [5:0] a, input logic [7:0] d,
                          input logic [4:0] n, input logic inc, output int acc);
    cmd_write = wr; cmd_address = a; cmd_wdata = d; cmd_count = n; cmd_incr = inc;
    cmd_valid = 1'b1;
    acc = -1;
    for (int t = 0; t < 400; t++) begin
      if (cmd_ready === 1'b1) begin
        acc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (acc < 0) check("cmd_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    // Scramble the command port; the running command must not notice.
    cmd_write = ~wr; cmd_address = ~a; cmd_wdata = ~d; cmd_count = ~n; cmd_incr = ~inc;
  endtask

  task automatic plan(input logic wr, input logic [5:0] a, input logic [7:0] d, input int n,
                      input logic inc, input int w, input int acc, input int nb, input int nr);
    beat_t b;
    rsp_t  r;
    for (int j = 0; j < nb; j++) begin
      b.addr = inc ? 6'(a + j) : a;
      b.data = 8'(d + j);
      b.wr   = wr;
      beatq.push_back(b);
    end
    for (int j = 0; j < nr; j++) begin
      r.data = wr ? 8'h00 : rdq[j];
      r.last = (j == n);
      r.tmo  = 1'b0;
      r.due  = acc + (j + 1) * (w + 2);
      rspq.push_back(r);
    end
  endtask

  task automatic push_beat(input logic [5:0] a, input logic [7:0] d, input logic wr);
    beat_t b;
    b.addr = a; b.data = d; b.wr = wr;
    beatq.push_back(b);
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 500; t++) begin
      if (rspq.size() == 0 && busy === 1'b0) break;
      @(posedge clk); #1;
    end
    check("drain", 32'(rspq.size() == 0 && busy === 1'b0), 32'd1);
    check("beats_done", 32'(beatq.size()), 32'd0);
  endtask

  // Slave model and bus/response monitor, evaluated on the falling edge.
  initial begin : slave_monitor
    rsp_t       r;
    beat_t      b;
    logic       strobe;
    logic       prev_strobe = 1'b0, prev_wait = 1'b0;
    logic [5:0] prev_addr = '0;
    logic [7:0] prev_wdata = '0;
    int         stall = 0, run = 0, last_run = 0;
    avm_test_waitrequest = 1'b0;
    avm_test_readdata    = 8'h00;
    forever begin
      @(negedge clk);
      if (cyc < 1) continue;
      strobe = avm_test_read | avm_test_write;
      if (strobe) run++;
      else begin
        if (run > 0) last_run = run;
        run = 0;
      end
      if (rsp_valid === 1'b1) begin
        if (rspq.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
        else begin
          r = rspq.pop_front();
          check("rsp_data", 32'(rsp_data), 32'(r.data));
          check("rsp_last", 32'(rsp_last), 32'(r.last));
          check("rsp_timeout", 32'(rsp_timeout), 32'(r.tmo));
          if (r.due >= 0) check("rsp_cycle", cyc, r.due);
          if (r.tmo) check("timeout_strobe_cycles", last_run, TO);
        end
      end
      if (prev_strobe && !prev_wait) check("gap_after_beat", 32'(strobe), 32'd0);
      if (strobe) begin
        check("rw_exclusive", 32'(avm_test_read & avm_test_write), 32'd0);
        if (prev_strobe && prev_wait) begin
          check("addr_stable", 32'(avm_test_address), 32'(prev_addr));
          check("wdata_stable", 32'(avm_test_writedata), 32'(prev_wdata));
        end
        if (stuck || stall < wait_cycles) begin
          avm_test_waitrequest = 1'b1;
          stall++;
        end else begin
          avm_test_waitrequest = 1'b0;
          stall = 0;
          if (beatq.size() == 0) check("unexpected_beat", 32'd1, 32'd0);
          else begin
            b = beatq.pop_front();
            check("beat_addr", 32'(avm_test_address), 32'(b.addr));
            check("beat_is_write", 32'(avm_test_write), 32'(b.wr));
            if (b.wr) check("beat_wdata", 32'(avm_test_writedata), 32'(b.data));
          end
          if (avm_test_read) avm_test_readdata = (rdq.size() > 0) ? rdq.pop_front() : 8'h00;
        end
      end else begin
        avm_test_waitrequest = 1'b0;
        stall = 0;
      end
      prev_strobe = strobe;
      prev_wait   = avm_test_waitrequest;
      prev_addr   = avm_test_address;
      prev_wdata  = avm_test_writedata;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int c, c2;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_wdata = '0;
    cmd_count = '0; cmd_incr = 1'b0;

    // Reset state
    wait_cycle(2);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_strobes", 32'(avm_test_read | avm_test_write), 32'd0);
    check("rst_address", 32'(avm_test_address), 32'd0);
    rst = 1'b0;
    check("ready_low_last_reset_cycle", 32'(cmd_ready), 32'd0);
    wait_cycle(3);
    check("ready_after_reset", 32'(cmd_ready), 32'd1);

    // 1: single read, no wait
    wait_cycles = 0;
    rdq.push_back(8'hA5);
    send_cmd(1'b0, 6'h05, 8'h00, 5'd0, 1'b1, c);
    plan(1'b0, 6'h05, 8'h00, 0, 1'b1, 0, c, 1, 1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_ready_low", 32'(cmd_ready), 32'd0);
    check("t1_read", 32'(avm_test_read), 32'd1);
    check("t1_write", 32'(avm_test_write), 32'd0);
    check("t1_addr", 32'(avm_test_address), 32'h05);
    wait_cycle(c + 2);
    check("t1_ready_with_rsp", 32'(cmd_ready), 32'd1);
    check("t1_busy_low", 32'(busy), 32'd0);
    wait_drain();

    // 2: write burst with 3 wait states, address and data wrap
    wait_cycles = 3;
    send_cmd(1'b1, 6'h3E, 8'hFE, 5'd2, 1'b1, c);
    push_beat(6'h3E, 8'hFE, 1'b1);
    push_beat(6'h3F, 8'hFF, 1'b1);
    push_beat(6'h00, 8'h00, 1'b1);
    plan(1'b1, 6'h3E, 8'hFE, 2, 1'b1, 3, c, 0, 3);
    wait_drain();

    // 3: timeout with waitrequest stuck, then a normal command
    stuck = 1'b1;
    send_cmd(1'b0, 6'h07, 8'h00, 5'd2, 1'b1, c);
    rspq.push_back('{data: 8'h00, last: 1'b1, tmo: 1'b1, due: c + 1 + TO});
    wait_drain();
    stuck = 1'b0;
    wait_cycles = 0;
    send_cmd(1'b1, 6'h2A, 8'h5C, 5'd0, 1'b0, c);
    plan(1'b1, 6'h2A, 8'h5C, 0, 1'b0, 0, c, 1, 1);
    wait_drain();

    // 4: fixed-address read burst
    wait_cycles = 2;
    rdq.push_back(8'h10); rdq.push_back(8'h11); rdq.push_back(8'h12); rdq.push_back(8'h13);
    send_cmd(1'b0, 6'h01, 8'h00, 5'd3, 1'b0, c);
    plan(1'b0, 6'h01, 8'h00, 3, 1'b0, 2, c, 4, 4);
    wait_drain();

    // 5: reset during beat 3 of an 8-beat write
    wait_cycles = 0;
    send_cmd(1'b1, 6'h10, 8'h20, 5'd7, 1'b1, c);
    plan(1'b1, 6'h10, 8'h20, 7, 1'b1, 0, c, 4, 3);
    wait_cycle(c + 7);
    check("t5_beat3_strobe", 32'(avm_test_write), 32'd1);
    rst = 1'b1;
    wait_cycle(c + 8);
    check("t5_strobes_dropped", 32'(avm_test_read | avm_test_write), 32'd0);
    check("t5_busy_low", 32'(busy), 32'd0);
    check("t5_ready_low", 32'(cmd_ready), 32'd0);
    wait_cycle(c + 9);
    rst = 1'b0;
    check("t5_ready_low_at_release", 32'(cmd_ready), 32'd0);
    wait_cycle(c + 10);
    check("t5_ready_after_release", 32'(cmd_ready), 32'd1);
    wait_cycle(c + 20);
    check("t5_no_pending_rsp", 32'(rspq.size()), 32'd0);
    check("t5_no_pending_beat", 32'(beatq.size()), 32'd0);

    // 6: command presented while busy is held off until IDLE
    wait_cycles = 1;
    rdq.push_back(8'h55); rdq.push_back(8'h66); rdq.push_back(8'h77);
    send_cmd(1'b0, 6'h08, 8'h00, 5'd2, 1'b1, c);
    plan(1'b0, 6'h08, 8'h00, 2, 1'b1, 1, c, 3, 3);
    wait_cycle(c + 3);
    check("t6_busy", 32'(busy), 32'd1);
    check("t6_ready_low", 32'(cmd_ready), 32'd0);
    send_cmd(1'b1, 6'h30, 8'h99, 5'd0, 1'b0, c2);
    check("t6_held_accept_cycle", c2, c + 9);
    plan(1'b1, 6'h30, 8'h99, 0, 1'b0, 1, c2, 1, 1);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
